// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to IMEM, buffers responses in a small
// in-order queue, and hands them to decode; redirects flush the queue and restart fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(QDEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     issue_pc_q, issue_pc_d;
    logic            inflight_q, inflight_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] instr_mem [QDEPTH];
    logic [31:0] pc_mem    [QDEPTH];

    logic [CntW:0] occupancy;
    logic          push;
    logic          pop;

    // Target is forced word aligned, so the low bits never matter.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
        imem_req  = !RST && !redirect_valid && (occupancy < DepthOcc);
        imem_addr = pc_q;
        id_valid  = !RST && (count_q != '0);
        id_instr  = id_valid ? instr_mem[rd_ptr_q] : 32'h0;
        id_pc     = id_valid ? pc_mem[rd_ptr_q] : 32'h0;
        // A redirect kills both the arriving response and any pop.
        push      = !RST && inflight_q && !redirect_valid;
        pop       = id_valid && id_ready && !redirect_valid;
    end

    always_comb begin
        pc_d       = pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = imem_req;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (imem_req) begin
            pc_d       = pc_q + 32'd4;
            issue_pc_d = pc_q;
        end

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            issue_pc_q <= 32'h0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= issue_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: IMEM model answers addr ^ A5A5_0000 one cycle after a request.
module tb_fetch_unit;

    localparam logic [31:0] Key = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_ready      (id_ready)
    );

    always #5 CLK = ~CLK;

    // Garbage when no request, so a push of an unissued slot shows up.
    always @(posedge CLK) begin
        imem_rdata <= imem_req ? (imem_addr ^ Key) : 32'hDEAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'h0, id_valid}, 32'h1);
        check_eq({tag, "_pc"}, id_pc, pc);
        check_eq({tag, "_instr"}, id_instr, pc ^ Key);
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, "_req"}, {31'h0, imem_req}, {31'h0, req});
        if (req) check_eq({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        RST            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rdata     = 32'h0;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check_fetch("rst", 1'b0, 32'h0);
        check_eq("rst_id_valid", {31'h0, id_valid}, 32'h0);
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_id_instr", id_instr, 32'h0);

        // Streaming with id_ready held high
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (k == 0) RST = 1'b0;
            #1;
            check_fetch("stream", 1'b1, 32'(4 * k));
            if (k < 2) check_eq("stream_empty", {31'h0, id_valid}, 32'h0);
            else       check_head("stream", 32'(4 * (k - 2)));
        end

        // Back-pressure from reset: exactly QDEPTH issues, head held
        @(negedge CLK);
        RST      = 1'b1;
        id_ready = 1'b0;
        #1;
        check_fetch("bp_rst", 1'b0, 32'h0);
        check_eq("bp_rst_valid", {31'h0, id_valid}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 0) RST = 1'b0;
            #1;
            check_fetch("bp_fill", k < 4, 32'(4 * k));
            if (k >= 2) check_head("bp_hold", 32'h0);
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            if (k == 0) id_ready = 1'b1;
            #1;
            check_head("bp_drain", 32'(4 * k));
        end

        // Single redirect in a steady stream
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check_fetch("redir_t0", 1'b0, 32'h0);
        @(negedge CLK);
        redirect_valid = 1'b0;
        #1;
        check_eq("redir_t1_valid", {31'h0, id_valid}, 32'h0);
        check_fetch("redir_t1", 1'b1, 32'h100);
        @(negedge CLK);
        #1;
        check_eq("redir_t2_valid", {31'h0, id_valid}, 32'h0);
        check_fetch("redir_t2", 1'b1, 32'h104);
        @(negedge CLK);
        #1;
        check_head("redir_t3", 32'h100);
        @(negedge CLK);
        #1;
        check_head("redir_t4", 32'h104);

        // Fill the queue, then redirect to a misaligned target alongside a pop
        @(negedge CLK);
        id_ready = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        check_fetch("full", 1'b0, 32'h0);
        check_head("full", 32'h108);
        @(negedge CLK);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        check_fetch("mis_t0", 1'b0, 32'h0);
        @(negedge CLK);
        redirect_valid = 1'b0;
        #1;
        check_eq("mis_t1_valid", {31'h0, id_valid}, 32'h0);
        check_fetch("mis_t1", 1'b1, 32'h200);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check_head("mis_t3", 32'h200);
        @(negedge CLK);
        #1;
        check_head("mis_t4", 32'h204);

        // Back-to-back redirects: last target wins
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        check_fetch("b2b_t0", 1'b0, 32'h0);
        @(negedge CLK);
        redirect_pc = 32'h400;
        #1;
        check_fetch("b2b_t1", 1'b0, 32'h0);
        check_eq("b2b_t1_valid", {31'h0, id_valid}, 32'h0);
        @(negedge CLK);
        redirect_valid = 1'b0;
        #1;
        check_fetch("b2b_t2", 1'b1, 32'h400);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check_head("b2b_t4", 32'h400);

        // Address wrap at the top of the space
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        check_fetch("wrap_t0", 1'b0, 32'h0);
        @(negedge CLK);
        redirect_valid = 1'b0;
        #1;
        check_fetch("wrap_t1", 1'b1, 32'hFFFF_FFFC);
        @(negedge CLK);
        #1;
        check_fetch("wrap_t2", 1'b1, 32'h0);
        @(negedge CLK);
        #1;
        check_fetch("wrap_t3", 1'b1, 32'h4);
        check_head("wrap_t3", 32'hFFFF_FFFC);
        @(negedge CLK);
        #1;
        check_head("wrap_t4", 32'h0);
        @(negedge CLK);
        #1;
        check_head("wrap_t5", 32'h4);

        // Reset pulse with three queued entries and one request in flight
        @(negedge CLK);
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        #1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            redirect_valid = 1'b0;
            #1;
            check_fetch("pre_rst", 1'b1, 32'h500 + 32'(4 * (k - 1)));
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_fetch("mid_rst", 1'b0, 32'h0);
        check_eq("mid_rst_valid", {31'h0, id_valid}, 32'h0);
        @(negedge CLK);
        RST      = 1'b0;
        id_ready = 1'b1;
        #1;
        check_eq("post_rst_t1_valid", {31'h0, id_valid}, 32'h0);
        check_fetch("post_rst_t1", 1'b1, 32'h0);
        @(negedge CLK);
        #1;
        check_eq("post_rst_t2_valid", {31'h0, id_valid}, 32'h0);
        check_fetch("post_rst_t2", 1'b1, 32'h4);
        @(negedge CLK);
        #1;
        check_head("post_rst_t3", 32'h0);
        @(negedge CLK);
        #1;
        check_head("post_rst_t4", 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
